// File: rtl/aes_kat_pkg.sv
// Shared types and the known-answer table for the AES-128 KAT self-test.
// Entries beyond the populated vectors are zero so unused indices read deterministically.
package aes_kat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } kat_state_e;

    localparam int KAT_DEPTH = 16;

    // Index 0 is the leftmost entry of each concatenation.
    localparam logic [0:KAT_DEPTH-1][127:0] VEC_STATE = {
        128'h3243f6a8885a308d313198a2e0370734,
        128'h00112233445566778899aabbccddeeff,
        128'h00000000000000000000000000000000,
        128'h00000000000000000000000000000000,
        128'h00000000000000000000000000000001,
        {11{128'h0}}
    };

    localparam logic [0:KAT_DEPTH-1][127:0] VEC_KEY = {
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'h000102030405060708090a0b0c0d0e0f,
        128'h00000000000000000000000000000000,
        128'h00000000000000000000000000000001,
        128'h00000000000000000000000000000000,
        {11{128'h0}}
    };

    localparam logic [0:KAT_DEPTH-1][127:0] VEC_EXP = {
        128'h3925841d02dc09fbdc118597196a0b32,
        128'h69c4e0d86a7b0430d8cdb78070b4c55a,
        128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
        128'h0545aad56da2a97c3663d1432a3d1c84,
        128'h58e2fccefa7e3061367f1d57a4e7455a,
        {11{128'h0}}
    };

endpackage

// File: rtl/aes_kat_rom.sv
// Combinational KAT lookup: vector index -> plaintext, key and expected ciphertext.
module aes_kat_rom
    import aes_kat_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 4
) (
    input  logic [CNT_W-1:0]  idx,
    output logic [DATA_W-1:0] vec_state,
    output logic [DATA_W-1:0] vec_key,
    output logic [DATA_W-1:0] vec_exp
);
    logic [3:0] rom_idx;

    assign rom_idx   = 4'(idx);
    assign vec_state = VEC_STATE[rom_idx][DATA_W-1:0];
    assign vec_key   = VEC_KEY[rom_idx][DATA_W-1:0];
    assign vec_exp   = VEC_EXP[rom_idx][DATA_W-1:0];

endmodule

// File: rtl/aes_kat_bist.sv
// Known-answer self-test sequencer for a pipelined AES-128 core: issues the KAT table,
// aligns returning ciphertexts with a valid/tag pipe and scores them.
module aes_kat_bist
    import aes_kat_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int NUM_VEC   = 5,
    parameter int LATENCY   = 21,
    parameter int ISSUE_GAP = 0,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] core_out,
    output logic [DATA_W-1:0] core_state,
    output logic [DATA_W-1:0] core_key,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_fail_idx
);
    localparam int               GAP_W      = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] ALL_ONES   = '1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(ISSUE_GAP);

    kat_state_e                       state_q, state_d;
    logic [CNT_W-1:0]                 idx_q, idx_d;
    logic [GAP_W-1:0]                 gap_q, gap_d;
    logic [DATA_W-1:0]                core_state_q, core_state_d;
    logic [DATA_W-1:0]                core_key_q, core_key_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;
    logic [CNT_W-1:0]                 err_q, err_d;
    logic [CNT_W-1:0]                 ffi_q, ffi_d;
    logic [LATENCY-1:0]               vld_q, vld_d;
    logic [LATENCY-1:0][CNT_W-1:0]    tag_q, tag_d;
    logic [DATA_W-1:0]                exp_q, exp_d;

    logic                             in_vld;
    logic [CNT_W-1:0]                 in_tag;
    logic                             head_busy;
    logic                             mismatch;
    logic [DATA_W-1:0]                iss_state, iss_key, iss_exp;
    logic [DATA_W-1:0]                chk_state, chk_key, chk_exp;
    logic                             unused_rom_bits;

    aes_kat_rom #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_rom_issue (
        .idx       (idx_q),
        .vec_state (iss_state),
        .vec_key   (iss_key),
        .vec_exp   (iss_exp)
    );

    // Expected value is looked up for the tag entering the last stage, so it lines up with it.
    aes_kat_rom #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_rom_check (
        .idx       (tag_d[LATENCY-1]),
        .vec_state (chk_state),
        .vec_key   (chk_key),
        .vec_exp   (chk_exp)
    );

    assign unused_rom_bits = ^{iss_exp, chk_state, chk_key};

    always_comb begin
        vld_d     = '0;
        tag_d     = '0;
        head_busy = 1'b0;
        vld_d[0]  = in_vld;
        tag_d[0]  = in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
        for (int i = 0; i < LATENCY - 1; i++) begin
            head_busy = head_busy | vld_q[i];
        end
        exp_d    = chk_exp;
        mismatch = vld_q[LATENCY-1] && (core_out !== exp_q);
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        core_state_d = '0;
        core_key_d   = '0;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        ffi_d        = ffi_q;
        in_vld       = 1'b0;
        in_tag       = '0;

        if (mismatch) begin
            if (err_q != ALL_ONES) err_d = err_q + 1'b1;
            if (ffi_q == ALL_ONES) ffi_d = tag_q[LATENCY-1];
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    idx_d   = '0;
                    gap_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = '0;
                    ffi_d   = ALL_ONES;
                end
            end
            ST_ISSUE: begin
                if (gap_q == '0) begin
                    core_state_d = iss_state;
                    core_key_d   = iss_key;
                    in_vld       = 1'b1;
                    in_tag       = idx_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        gap_d = GAP_RELOAD;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            // The tail stage is scored on this same edge, so only the head stages must be empty.
            ST_DRAIN: begin
                if (!head_busy) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            gap_q        <= '0;
            core_state_q <= '0;
            core_key_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= '0;
            ffi_q        <= ALL_ONES;
            vld_q        <= '0;
            tag_q        <= '0;
            exp_q        <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            core_state_q <= core_state_d;
            core_key_q   <= core_key_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ffi_q        <= ffi_d;
            vld_q        <= vld_d;
            tag_q        <= tag_d;
            exp_q        <= exp_d;
        end
    end

    assign core_state     = core_state_q;
    assign core_key       = core_key_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = done_q && (err_q == '0);
    assign err_count      = err_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_aes_kat_bist.sv
// Bench for aes_kat_bist: a delay-line AES core model with per-vector corruption drives a
// default instance and a gapped, short-latency instance through directed runs.
module tb_aes_kat_bist;

    localparam int LAT_A = 21;
    localparam int LAT_B = 3;

    logic         clk;
    logic         rst_n;
    logic         startA, startB;
    logic [127:0] coreOutA, coreOutB;
    logic [127:0] coreStateA, coreKeyA, coreStateB, coreKeyB;
    logic         busyA, doneA, passA, busyB, doneB, passB;
    logic [3:0]   errA, ffiA, errB, ffiB;
    logic [4:0]   corruptMask;

    int checks = 0;
    int errors = 0;

    logic [127:0] tbState [5] = '{
        128'h3243f6a8885a308d313198a2e0370734, 128'h00112233445566778899aabbccddeeff,
        128'h0, 128'h0, 128'h1};
    logic [127:0] tbKey [5] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h000102030405060708090a0b0c0d0e0f,
        128'h0, 128'h1, 128'h0};
    logic [127:0] tbCt [5] = '{
        128'h3925841d02dc09fbdc118597196a0b32, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
        128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0545aad56da2a97c3663d1432a3d1c84,
        128'h58e2fccefa7e3061367f1d57a4e7455a};

    logic [127:0] seenState [8];
    logic [127:0] seenKey [8];
    logic [127:0] dlA [LAT_A-1];
    logic [127:0] dlB [LAT_B-1];

    aes_kat_bist dut (
        .clk(clk), .rst_n(rst_n), .start(startA), .core_out(coreOutA),
        .core_state(coreStateA), .core_key(coreKeyA), .busy(busyA), .done(doneA),
        .pass(passA), .err_count(errA), .first_fail_idx(ffiA)
    );

    aes_kat_bist #(.LATENCY(LAT_B), .ISSUE_GAP(2)) dutGap (
        .clk(clk), .rst_n(rst_n), .start(startB), .core_out(coreOutB),
        .core_state(coreStateB), .core_key(coreKeyB), .busy(busyB), .done(doneB),
        .pass(passB), .err_count(errB), .first_fail_idx(ffiB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // core_state itself is the core's first register, so the model adds LATENCY-1 stages.
    function automatic logic [127:0] coreModel(input logic [127:0] st, input logic [127:0] key,
                                               input logic [4:0] mask);
        coreModel = '0;
        for (int i = 0; i < 5; i++) begin
            if (st == tbState[i] && key == tbKey[i]) coreModel = tbCt[i] ^ {127'b0, mask[i]};
        end
    endfunction

    always @(posedge clk) begin
        dlA[0] <= coreModel(coreStateA, coreKeyA, corruptMask);
        for (int i = 1; i < LAT_A - 1; i++) dlA[i] <= dlA[i-1];
        dlB[0] <= coreModel(coreStateB, coreKeyB, 5'b0);
        for (int i = 1; i < LAT_B - 1; i++) dlB[i] <= dlB[i-1];
    end

    assign coreOutA = dlA[LAT_A-2];
    assign coreOutB = dlB[LAT_B-2];

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Pulses start on the default instance and counts cycles until done (bounded).
    task automatic applyStimulus(input int midStartAt, input int abortAt, output int nCycles);
        nCycles = 0;
        startA  = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        while (nCycles < 200) begin
            @(negedge clk);
            nCycles++;
            if (nCycles < 8) begin
                seenState[nCycles] = coreStateA;
                seenKey[nCycles]   = coreKeyA;
            end
            if (nCycles == abortAt) return;
            if (doneA) break;
            startA = (nCycles == midStartAt);
        end
        startA = 1'b0;
    endtask

    initial begin
        int n;
        logic [127:0] gs2, gs4, gk4;
        rst_n = 1'b0;
        startA = 1'b0;
        startB = 1'b0;
        corruptMask = 5'b0;
        gs2 = '0;
        gs4 = '0;
        gk4 = '0;

        repeat (3) @(negedge clk);
        checkOutput("rstBusy", busyA, 0);
        checkOutput("rstDone", doneA, 0);
        checkOutput("rstPass", passA, 0);
        checkOutput("rstErr", errA, 0);
        checkOutput("rstFfi", ffiA, 4'hf);
        checkOutput("rstState", coreStateA, 0);
        checkOutput("rstKey", coreKeyA, 0);
        rst_n = 1'b1;

        repeat (50) @(negedge clk);
        checkOutput("idleBusy", busyA, 0);
        checkOutput("idleDone", doneA, 0);
        checkOutput("idleState", coreStateA, 0);

        applyStimulus(-1, -1, n);
        checkOutput("goldLatency", 128'(n), 26);
        checkOutput("goldPass", passA, 1);
        checkOutput("goldErr", errA, 0);
        checkOutput("goldFfi", ffiA, 4'hf);
        checkOutput("goldBusyAfter", busyA, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("goldState%0d", i), seenState[i+1], tbState[i]);
            checkOutput($sformatf("goldKey%0d", i), seenKey[i+1], tbKey[i]);
        end
        checkOutput("goldDrainState", seenState[6], 0);
        checkOutput("goldDrainKey", seenKey[6], 0);

        corruptMask = 5'b00100;
        applyStimulus(-1, -1, n);
        checkOutput("bad2Err", errA, 1);
        checkOutput("bad2Ffi", ffiA, 2);
        checkOutput("bad2Pass", passA, 0);
        checkOutput("bad2Done", doneA, 1);

        corruptMask = 5'b01010;
        applyStimulus(-1, -1, n);
        checkOutput("bad13Err", errA, 2);
        checkOutput("bad13Ffi", ffiA, 1);
        checkOutput("bad13Pass", passA, 0);

        corruptMask = 5'b0;
        applyStimulus(-1, -1, n);
        checkOutput("rerunErr", errA, 0);
        checkOutput("rerunPass", passA, 1);

        applyStimulus(3, -1, n);
        checkOutput("busyStartLatency", 128'(n), 26);
        checkOutput("busyStartPass", passA, 1);
        checkOutput("busyStartFfi", ffiA, 4'hf);

        applyStimulus(25, -1, n);
        checkOutput("edgeStartLatency", 128'(n), 26);
        repeat (3) @(negedge clk);
        checkOutput("edgeStartBusy", busyA, 0);
        checkOutput("edgeStartDone", doneA, 1);
        checkOutput("edgeStartPass", passA, 1);

        corruptMask = 5'b11111;
        applyStimulus(-1, 4, n);
        checkOutput("abortIssueKey", coreKeyA, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abortBusy", busyA, 0);
        checkOutput("abortKey", coreKeyA, 0);
        checkOutput("abortFfi", ffiA, 4'hf);
        checkOutput("abortDone", doneA, 0);
        corruptMask = 5'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(-1, -1, n);
        checkOutput("freshLatency", 128'(n), 26);
        checkOutput("freshPass", passA, 1);

        n = 0;
        startB = 1'b1;
        @(negedge clk);
        startB = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (n == 2) gs2 = coreStateB;
            if (n == 4) begin
                gs4 = coreStateB;
                gk4 = coreKeyB;
            end
            if (doneB) break;
        end
        checkOutput("gapLatency", 128'(n), 16);
        checkOutput("gapPass", passB, 1);
        checkOutput("gapFfi", ffiB, 4'hf);
        checkOutput("gapIdleState", gs2, 0);
        checkOutput("gapState1", gs4, tbState[1]);
        checkOutput("gapKey1", gk4, tbKey[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
